// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array sequencing controller.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } ctrl_state_e;

    localparam int unsigned DEFAULT_N    = 4;
    localparam int unsigned FLUSH_CYCLES = 2 * DEFAULT_N - 2;

    // Wavefront flush length for an n x n array.
    function automatic int unsigned flush_len(input int unsigned n);
        return 2 * n - 2;
    endfunction

    // Step counter must hold both k_len-1 and the flush length minus one.
    function automatic int unsigned step_width(input int unsigned kw, input int unsigned n);
        int unsigned fw;
        fw = $clog2(2 * n - 1);
        return (kw > fw) ? kw : fw;
    endfunction

endpackage

// File: rtl/systolic_ctrl_step_counter.sv
// Parameterized up-counter with synchronous active-low reset, zero-load and enable.
module step_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for the N x N output-stationary systolic MAC array:
// clear, feed K columns, flush the skewed wavefront, drain N rows.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned KW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    output logic                 busy,
    output logic                 acc_clear,
    output logic                 feed_en,
    output logic                 operand_valid,
    output logic [KW-1:0]        feed_idx,
    output logic [$clog2(N)-1:0] row_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 done
);

    localparam int unsigned CW = step_width(KW, N);
    localparam int unsigned RW = $clog2(N);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(flush_len(N) - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

    ctrl_state_e   state, state_nx;
    logic [KW-1:0] k_reg;
    logic [CW-1:0] step;
    logic [RW-1:0] row;
    logic          reload;
    logic          step_en;
    logic          row_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            k_reg <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start && k_len != '0)
                k_reg <= k_len;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && k_len != '0) state_nx = CLEAR;
            CLEAR:   state_nx = FEED;
            FEED:    if (step == CW'(k_reg) - CW'(1)) state_nx = FLUSH;
            FLUSH:   if (step == FLUSH_LAST) state_nx = DRAIN;
            DRAIN:   if (out_ready && row == ROW_LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Both counters restart from zero whenever the phase changes.
    assign reload  = (state_nx != state);
    assign step_en = (state == FEED) || (state == FLUSH);
    assign row_en  = (state == DRAIN) && out_ready;

    step_counter #(.W(CW)) u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (reload),
        .en    (step_en),
        .count (step)
    );

    step_counter #(.W(RW)) u_row (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (reload),
        .en    (row_en),
        .count (row)
    );

    always_comb begin
        busy          = 1'b0;
        acc_clear     = 1'b0;
        feed_en       = 1'b0;
        operand_valid = 1'b0;
        feed_idx      = '0;
        row_sel       = '0;
        out_valid     = 1'b0;
        done          = 1'b0;
        case (state)
            CLEAR: begin
                busy      = 1'b1;
                acc_clear = 1'b1;
            end
            FEED: begin
                busy          = 1'b1;
                feed_en       = 1'b1;
                operand_valid = 1'b1;
                feed_idx      = step[KW-1:0];
            end
            FLUSH: begin
                busy    = 1'b1;
                feed_en = 1'b1;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                row_sel   = row;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: tile timing table, corner sequences, randomized model check.
module tb_systolic_ctrl;

    localparam int N  = 4;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            out_ready = 1'b1;
    logic            busy, acc_clear, feed_en, operand_valid, out_valid, done;
    logic [KW-1:0]   feed_idx;
    logic [$clog2(N)-1:0] row_sel;

    int nchk = 0;
    int nerr = 0;

    systolic_ctrl #(.N(N), .KW(KW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .k_len         (k_len),
        .busy          (busy),
        .acc_clear     (acc_clear),
        .feed_en       (feed_en),
        .operand_valid (operand_valid),
        .feed_idx      (feed_idx),
        .row_sel       (row_sel),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;
        int stall_row;
        int stall_len;
        int exp_done;
    } tile_t;

    typedef struct {
        int busy, acc_clear, feed_en, operand_valid, feed_idx, row_sel, out_valid, done;
    } exp_t;

    tile_t tiles[5];

    // Reference model: cycles since acceptance, latched K and rows handed off.
    int m_t = -1;
    int m_k = 0;
    int m_rows = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '{default: 0};
        if (m_t < 0) return e;
        e.busy = 1;
        if (m_t == 1) e.acc_clear = 1;
        else if (m_t <= m_k + 1) begin
            e.feed_en = 1; e.operand_valid = 1; e.feed_idx = m_t - 2;
        end else if (m_t <= m_k + 2 * N - 1) e.feed_en = 1;
        else if (m_rows < N) begin
            e.out_valid = 1; e.row_sel = m_rows;
        end else e.done = 1;
        return e;
    endfunction

    task automatic model_step(input logic rst, input logic st, input int k, input logic rdy);
        if (!rst) begin
            m_t = -1; m_rows = 0;
        end else if (m_t < 0) begin
            if (st && k != 0) begin m_t = 1; m_k = k; m_rows = 0; end
        end else if (m_rows == N) begin
            m_t = -1;
        end else begin
            if (m_t >= m_k + 2 * N && rdy) m_rows++;
            m_t++;
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".busy"}, busy, e.busy);
        chk({tag, ".acc_clear"}, acc_clear, e.acc_clear);
        chk({tag, ".feed_en"}, feed_en, e.feed_en);
        chk({tag, ".operand_valid"}, operand_valid, e.operand_valid);
        chk({tag, ".feed_idx"}, feed_idx, e.feed_idx);
        chk({tag, ".row_sel"}, row_sel, e.row_sel);
        chk({tag, ".out_valid"}, out_valid, e.out_valid);
        chk({tag, ".done"}, done, e.done);
    endtask

    task automatic run_tile(input int idx, input tile_t v);
        int clear_cyc = -1, feeds = 0, last_idx = -1, first_valid = -1;
        int done_cyc = -1, stall_left, dones = 0;
        string tag;
        tag = $sformatf("tile%0d", idx);
        stall_left = v.stall_len;
        start = 1'b1; k_len = KW'(v.k); out_ready = 1'b1;
        tick();
        start = 1'b0;
        k_len = KW'($urandom_range(0, 255));
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (acc_clear && clear_cyc < 0) clear_cyc = cyc;
            if (operand_valid) begin feeds++; last_idx = int'(feed_idx); end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && int'(row_sel) == v.stall_row && stall_left > 0) begin
                out_ready = 1'b0; stall_left--;
            end else out_ready = 1'b1;
            if (done) begin dones++; done_cyc = cyc; break; end
            tick();
        end
        tick();
        chk({tag, ".clear_cycle"}, clear_cyc, 1);
        chk({tag, ".feed_cycles"}, feeds, v.k);
        chk({tag, ".last_feed_idx"}, last_idx, v.k - 1);
        chk({tag, ".drain_start"}, first_valid, v.k + 2 * N);
        chk({tag, ".done_cycle"}, done_cyc, v.exp_done);
        chk({tag, ".done_pulses"}, dones, 1);
        chk({tag, ".idle_after"}, busy, 0);
    endtask

    initial begin
        exp_t zero;
        int clears[$];
        int dones, cyc, hit;
        zero = '{default: 0};
        tiles[0] = '{k: 3,   stall_row: -1, stall_len: 0, exp_done: 15};
        tiles[1] = '{k: 3,   stall_row: 2,  stall_len: 3, exp_done: 18};
        tiles[2] = '{k: 1,   stall_row: -1, stall_len: 0, exp_done: 13};
        tiles[3] = '{k: 255, stall_row: -1, stall_len: 0, exp_done: 267};
        tiles[4] = '{k: 7,   stall_row: 0,  stall_len: 5, exp_done: 24};

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        chk_all("reset", zero);
        rst_n = 1'b1;
        tick();

        // start with k_len = 0 is ignored
        start = 1'b1; k_len = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("k0_busy[%0d]", i), busy, 0);
            chk($sformatf("k0_done[%0d]", i), done, 0);
        end
        start = 1'b0;

        for (int i = 0; i < 5; i++) run_tile(i, tiles[i]);

        // Reset during FEED at feed_idx = 1
        start = 1'b1; k_len = 8'd5;
        tick();
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 10; i++) begin
            if (operand_valid && feed_idx == 8'd1) begin hit = 1; break; end
            tick();
        end
        chk("midreset.reached_feed1", hit, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_all("midreset", zero);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) dones++;
        end
        chk("midreset.no_activity", dones, 0);
        run_tile(5, tiles[0]);

        // start held high: back-to-back k_len=1 tiles
        start = 1'b1; k_len = 8'd1;
        dones = 0;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (acc_clear) clears.push_back(c);
            if (done) dones++;
        end
        start = 1'b0;
        chk("b2b.clear_count", clears.size(), 4);
        if (clears.size() > 0) chk("b2b.first_clear", clears[0], 1);
        for (int i = 1; i < clears.size(); i++)
            chk($sformatf("b2b.gap%0d", i), clears[i] - clears[i-1], 14);
        chk("b2b.done_count", dones, 3);
        cyc = 0;
        while (busy && cyc < 40) begin tick(); cyc++; end
        chk("b2b.returns_idle", busy, 0);

        // Randomized traffic against the reference model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_t = -1; m_rows = 0;
        for (int c = 0; c < 3000; c++) begin
            logic r, s, rd;
            int k;
            chk_all($sformatf("rand%0d", c), model_out());
            s  = ($urandom_range(0, 2) == 0);
            k  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 9));
            rd = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 149) != 0);
            start = s; k_len = KW'(k); out_ready = rd; rst_n = r;
            model_step(r, s, k, rd);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for the N×N output-stationary systolic MAC array. One `start` request runs a full tile: it clears the accumulators, streams K operand columns, flushes the skewed wavefront, then drains N result rows over a valid/ready port. It drives the `clear`/`enable` controls of every PE pipeline and accumulator register and sits between the host/DMA command interface and the array.

## Interface
- `N`, default 4: array dimension; must be ≥ 2.
- `KW`, default 8: width of the K-length field; K ranges 1..2^KW−1.
- `clk`  input  1: single clock, rising edge.
- `rst_n`  input  1: reset, synchronous, active-low.
- `start`  input  1: tile request, sampled only in IDLE.
- `k_len`  input  KW: operand columns in the tile, latched on accepted `start`.
- `busy`  output  1: high in every state except IDLE.
- `acc_clear`  output  1: to all accumulator register `clear` inputs.
- `feed_en`  output  1: to all PE pipeline register `enable` inputs.
- `operand_valid`  output  1: edge feeders inject real operands when high and zeros when low.
- `feed_idx`  output  KW: operand column currently injected.
- `row_sel`  output  $clog2(N): result row presented on the drain port.
- `out_valid`  output  1: drain data valid.
- `out_ready`  input  1: downstream accepts drain data.
- `done`  output  1: one-cycle pulse at tile completion.

## Operation
- Moore FSM. Every output is decoded from the state and counter registers only, with no combinational input-to-output path.
- IDLE: all outputs 0. If `start`=1 and `k_len`≠0, latch `k_len` and go to CLEAR. `start` with `k_len`=0 is ignored: the FSM stays in IDLE and `done` does not pulse.
- CLEAR, 1 cycle: `acc_clear`=1, `feed_en`=0. Next state is FEED.
- FEED, k_len cycles: `feed_en`=1, `operand_valid`=1, `feed_idx` counts 0..k_len−1. Next state is FLUSH.
- FLUSH, 2N−2 cycles: `feed_en`=1, `operand_valid`=0, `feed_idx`=0. Next state is DRAIN.
- DRAIN: `feed_en`=0 so the array holds, `out_valid`=1, `row_sel` starts at 0.
  - `row_sel` advances only on `out_valid && out_ready`.
  - The handshake on row N−1 moves the FSM to DONE.
  - While `out_ready`=0, state and `row_sel` hold indefinitely.
- DONE, 1 cycle: `done`=1. Next state is IDLE.
- A `start` asserted while `busy`=1 is ignored and is not queued. `start` asserted in the DONE cycle is also ignored.
- A `k_len` change after acceptance has no effect on the running tile.
- `rst_n`=0 at any edge, including mid-tile: the next state is IDLE, all counters are 0, and all outputs are 0 in the following cycle. No `done` pulse is issued for the aborted tile.

## Timing
- Reset values: `busy`, `acc_clear`, `feed_en`, `operand_valid`, `out_valid`, `done` = 0; `feed_idx` = 0; `row_sel` = 0.
- Cycle numbering is relative to the edge that accepts `start` (cycle 0):
  - cycle 1: CLEAR.
  - cycles 2..K+1: FEED.
  - cycles K+2..K+2N−1: FLUSH.
  - DRAIN begins at cycle K+2N.
- With `out_ready` held at 1, DRAIN lasts N cycles and `done` is high in cycle K+3N.
- Minimum gap between tiles: after the DONE cycle the FSM spends one cycle in IDLE, so the next `start` can be accepted at the edge ending that IDLE cycle.
- Counter width: the internal step counter is max(KW, $clog2(2N−1)) bits. It is reloaded to 0 on every state transition and never wraps within a state.

## Structure
- Shared package `systolic_pkg` holds:
  - `ctrl_state_e` enum: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
  - localparam `FLUSH_CYCLES` = 2N−2.
  - the counter-width function.
- One sub-module, `step_counter`: a parameterized-width up-counter with synchronous active-low reset, synchronous zero-load and enable.
  - It is instantiated twice: once as the phase step counter, once as the drain row counter.
- The FSM state register and the `k_len` latch use the same synchronous reset.

## Test plan
- N=4, `k_len`=3, `out_ready`=1 → CLEAR in cycle 1; `feed_idx`=0,1,2 in cycles 2–4; FLUSH in cycles 5–10; `row_sel`=0..3 in cycles 11–14; `done` in cycle 15 only.
- Same tile with `out_ready` low for 3 cycles while `row_sel`=2 → `row_sel` holds at 2 with `out_valid`=1 throughout; `done` moves to cycle 18.
- `start` held high continuously with `k_len`=1 → tiles back-to-back, each 1+1+6+4+1 cycles plus 1 IDLE cycle; no tile is accepted while `busy`=1.
- `start` with `k_len`=0 → `busy` stays 0 and `done` never pulses.
- `rst_n`=0 for 1 cycle during FEED (`feed_idx`=1) → the next cycle shows all outputs 0 and IDLE; no `done`; a fresh `start` then runs a normal tile.
- `k_len`=255 (maximum) → 255 FEED cycles with `feed_idx` ending at 254 without wrap; `done` in cycle 267.
